axi_partition_tagger: RTL and testbench

Address-range-based AXI partition tagger sitting between a CPU-side AXI master port and the memory/LLC-side port. It inspects every AW and AR address, matches it against a PMP-style table of up to `MAXPARTITION` regions programmed over a 32-bit register bus, and writes the matching partition ID into a bit-field of the request user signal. All other AXI traffic passes through unchanged with zero latency.

---
 rtl/axi_partition_tagger.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_partition_tagger.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_partition_tagger.sv
// AXI partition tagger: tags AW/AR user bits with the partition ID of the first
// matching address region; region table is shadow/active double-buffered over regbus.
package axi_partition_tagger_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  user;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [7:0]  user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [7:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [7:0]  user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_b_chan_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_r_chan_t r;
    logic        r_valid;
  } axi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module axi_partition_tagger #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 48,
  parameter int unsigned MAXPARTITION    = 16,
  parameter int unsigned AXI_USER_ID_MSB = 7,
  parameter int unsigned AXI_USER_ID_LSB = 3,
  parameter int unsigned TAGGER_GRAN     = 3,
  parameter type axi_req_t = axi_partition_tagger_pkg::axi_req_t,
  parameter type axi_rsp_t = axi_partition_tagger_pkg::axi_rsp_t,
  parameter type reg_req_t = axi_partition_tagger_pkg::reg_req_t,
  parameter type reg_rsp_t = axi_partition_tagger_pkg::reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_rsp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_rsp_i,
  input  reg_req_t cfg_req_i,
  output reg_rsp_t cfg_rsp_o
);

  localparam int unsigned PW          = AXI_USER_ID_MSB - AXI_USER_ID_LSB + 1;
  localparam int unsigned NumPatWords = (MAXPARTITION + 5) / 6;
  localparam int unsigned PatWord0    = MAXPARTITION + 1;
  localparam int unsigned ConfWord    = PatWord0 + NumPatWords;
  localparam logic [31:0] TorClr      = 32'((64'd1 << TAGGER_GRAN) - 64'd1);
  localparam logic [31:0] NapotSet    =
    (TAGGER_GRAN >= 2) ? 32'((64'd1 << (TAGGER_GRAN - 1)) - 64'd1) : '0;

  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeTor   = 2'b01,
    ModeNa4   = 2'b10,
    ModeNapot = 2'b11
  } mode_e;

  logic [31:0]   addr_sh_q [MAXPARTITION], addr_sh_d [MAXPARTITION];
  logic [31:0]   addr_act_q[MAXPARTITION], addr_act_d[MAXPARTITION];
  logic [PW-1:0] pat_sh_q  [MAXPARTITION], pat_sh_d  [MAXPARTITION];
  logic [PW-1:0] pat_act_q [MAXPARTITION], pat_act_d [MAXPARTITION];
  mode_e         conf_sh_q [MAXPARTITION], conf_sh_d [MAXPARTITION];
  mode_e         conf_act_q[MAXPARTITION], conf_act_d[MAXPARTITION];

  logic [29:0] widx;
  logic        hit;
  logic [31:0] rd_word, wmask, wmerged;
  logic        wr_en, commit;
  logic        unused_dw;

  assign unused_dw = DATA_WIDTH[0];
  assign widx      = cfg_req_i.addr[31:2];

  // Decode the register word and assemble its shadow read value.
  always_comb begin
    hit     = 1'b0;
    rd_word = '0;
    if (cfg_req_i.addr[1:0] == 2'b00) begin
      if (widx == '0) hit = 1'b1;
      for (int unsigned i = 0; i < MAXPARTITION; i++) begin
        if (widx == 30'(i + 1)) begin
          hit     = 1'b1;
          rd_word = addr_sh_q[i];
        end
        if (widx == 30'(PatWord0 + i / 6)) begin
          hit                        = 1'b1;
          rd_word[5*(i%6) +: PW]     = pat_sh_q[i];
        end
      end
      if (widx == 30'(ConfWord)) begin
        hit = 1'b1;
        for (int unsigned i = 0; i < MAXPARTITION; i++) rd_word[2*i +: 2] = conf_sh_q[i];
      end
    end
  end

  assign wmask   = {{8{cfg_req_i.wstrb[3]}}, {8{cfg_req_i.wstrb[2]}},
                    {8{cfg_req_i.wstrb[1]}}, {8{cfg_req_i.wstrb[0]}}};
  assign wmerged = (rd_word & ~wmask) | (cfg_req_i.wdata & wmask);
  assign wr_en   = cfg_req_i.valid && cfg_req_i.write && hit;
  assign commit  = wr_en && (widx == '0) && cfg_req_i.wstrb[0] && cfg_req_i.wdata[0];

  always_comb begin
    cfg_rsp_o       = '0;
    cfg_rsp_o.ready = cfg_req_i.valid;
    cfg_rsp_o.error = cfg_req_i.valid && !hit;
    cfg_rsp_o.rdata = (cfg_req_i.valid && !cfg_req_i.write) ? rd_word : '0;
  end

  always_comb begin
    addr_sh_d  = addr_sh_q;
    pat_sh_d   = pat_sh_q;
    conf_sh_d  = conf_sh_q;
    addr_act_d = addr_act_q;
    pat_act_d  = pat_act_q;
    conf_act_d = conf_act_q;
    if (wr_en) begin
      for (int unsigned i = 0; i < MAXPARTITION; i++) begin
        if (widx == 30'(i + 1))               addr_sh_d[i] = wmerged;
        if (widx == 30'(PatWord0 + i / 6))    pat_sh_d[i]  = wmerged[5*(i%6) +: PW];
        if (widx == 30'(ConfWord))            conf_sh_d[i] = mode_e'(wmerged[2*i +: 2]);
      end
    end
    if (commit) begin
      addr_act_d = addr_sh_q;
      pat_act_d  = pat_sh_q;
      conf_act_d = conf_sh_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MAXPARTITION; i++) begin
        addr_sh_q[i]  <= '0;
        addr_act_q[i] <= '0;
        pat_sh_q[i]   <= '0;
        pat_act_q[i]  <= '0;
        conf_sh_q[i]  <= ModeOff;
        conf_act_q[i] <= ModeOff;
      end
    end else begin
      addr_sh_q  <= addr_sh_d;
      addr_act_q <= addr_act_d;
      pat_sh_q   <= pat_sh_d;
      pat_act_q  <= pat_act_d;
      conf_sh_q  <= conf_sh_d;
      conf_act_q <= conf_act_d;
    end
  end

  logic [ADDR_WIDTH-1:0] tor_lo    [MAXPARTITION];
  logic [ADDR_WIDTH-1:0] tor_hi    [MAXPARTITION];
  logic [ADDR_WIDTH-1:0] napot_base[MAXPARTITION];
  logic [ADDR_WIDTH-1:0] napot_mask[MAXPARTITION];
  logic                  napot_all [MAXPARTITION];

  // NAPOT: x ^ (x+1) yields ones over the trailing-ones run plus the next bit,
  // which is exactly the set of address bits the region ignores (after <<2).
  always_comb begin : p_region
    logic [ADDR_WIDTH-1:0] ext_n, run_n;
    ext_n     = '0;
    run_n     = '0;
    tor_lo[0] = '0;
    for (int unsigned i = 0; i + 1 < MAXPARTITION; i++)
      tor_lo[i+1] = ADDR_WIDTH'(addr_act_q[i] & ~TorClr) << 2;
    for (int unsigned i = 0; i < MAXPARTITION; i++) begin
      tor_hi[i]     = ADDR_WIDTH'(addr_act_q[i] & ~TorClr) << 2;
      ext_n         = ADDR_WIDTH'(addr_act_q[i] | NapotSet);
      run_n         = ext_n ^ (ext_n + ADDR_WIDTH'(1));
      napot_base[i] = {ext_n[ADDR_WIDTH-3:0], 2'b00};
      napot_mask[i] = {run_n[ADDR_WIDTH-3:0], 2'b11};
      napot_all[i]  = &(addr_act_q[i] | NapotSet);
    end
  end

  function automatic logic entry_hit(input mode_e m, input logic [ADDR_WIDTH-1:0] a,
                                     input logic [ADDR_WIDTH-1:0] lo, input logic [ADDR_WIDTH-1:0] hi,
                                     input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH-1:0] mask,
                                     input logic all_m);
    logic h;
    h = 1'b0;
    case (m)
      ModeTor:   h = (a >= lo) && (a < hi);
      ModeNapot: h = all_m || (((a ^ base) & ~mask) == '0);
      default:   h = 1'b0;
    endcase
    return h;
  endfunction

  logic [PW-1:0] aw_tag, ar_tag;

  always_comb begin : p_lookup
    logic aw_found, ar_found;
    aw_tag   = '0;
    ar_tag   = '0;
    aw_found = 1'b0;
    ar_found = 1'b0;
    for (int unsigned i = 0; i < MAXPARTITION; i++) begin
      if (!aw_found && entry_hit(conf_act_q[i], slv_req_i.aw.addr, tor_lo[i], tor_hi[i],
                                 napot_base[i], napot_mask[i], napot_all[i])) begin
        aw_found = 1'b1;
        aw_tag   = pat_act_q[i];
      end
      if (!ar_found && entry_hit(conf_act_q[i], slv_req_i.ar.addr, tor_lo[i], tor_hi[i],
                                 napot_base[i], napot_mask[i], napot_all[i])) begin
        ar_found = 1'b1;
        ar_tag   = pat_act_q[i];
      end
    end
  end

  always_comb begin
    mst_req_o = slv_req_i;
    mst_req_o.aw.user[AXI_USER_ID_MSB:AXI_USER_ID_LSB] = aw_tag;
    mst_req_o.ar.user[AXI_USER_ID_MSB:AXI_USER_ID_LSB] = ar_tag;
    slv_rsp_o = mst_rsp_i;
  end

endmodule

// File: tb/tb_axi_partition_tagger.sv
// Randomized self-checking bench for axi_partition_tagger against a word-level
// register model and an arithmetic range-match model.
module tb_axi_partition_tagger;
  import axi_partition_tagger_pkg::*;

  localparam int MAXP = 16;
  localparam int G    = 3;
  localparam int PB   = 1 + MAXP;
  localparam int NPW  = (MAXP + 5) / 6;
  localparam int CW   = PB + NPW;
  localparam int NW   = CW + 1;

  logic     clk = 1'b0;
  logic     rst;
  axi_req_t slv_req, mst_req;
  axi_rsp_t slv_rsp, mst_rsp;
  reg_req_t cfg_req;
  reg_rsp_t cfg_rsp;

  axi_partition_tagger #(
    .DATA_WIDTH(64), .ADDR_WIDTH(48), .MAXPARTITION(MAXP),
    .AXI_USER_ID_MSB(7), .AXI_USER_ID_LSB(3), .TAGGER_GRAN(G)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req), .mst_rsp_i(mst_rsp),
    .cfg_req_i(cfg_req), .cfg_rsp_o(cfg_rsp)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  logic [31:0] sh_w [NW];
  logic [31:0] act_w[NW];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] wmask_of(input int w);
    int n;
    if (w >= 1 && w <= MAXP) return 32'hFFFF_FFFF;
    if (w >= PB && w < CW) begin
      n = MAXP - 6 * (w - PB);
      if (n > 6) n = 6;
      return 32'((64'd1 << (5 * n)) - 64'd1);
    end
    if (w == CW) return 32'((64'd1 << (2 * MAXP)) - 64'd1);
    return 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    int w;
    logic [31:0] bm;
    w  = int'(off >> 2);
    bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (off[1:0] != 2'b00 || off >= 32'(4 * NW)) return;
    if (w == 0) begin
      if (s[0] && d[0]) act_w = sh_w;
    end else begin
      sh_w[w] = (sh_w[w] & ~bm) | (d & bm & wmask_of(w));
    end
  endfunction

  function automatic logic [4:0] pat_of(input int i);
    return 5'((act_w[PB + i / 6] >> (5 * (i % 6))) & 32'h1F);
  endfunction

  // Region semantics from first principles: trailing-ones count, explicit base/size.
  function automatic logic [4:0] model_tag(input longint unsigned a);
    longint unsigned ad, lo, hi, base, size;
    int m, t;
    for (int i = 0; i < MAXP; i++) begin
      m  = int'((act_w[CW] >> (2 * i)) & 32'h3);
      ad = longint'(act_w[1 + i]);
      if (m == 1) begin
        hi = ((ad >> G) << G) << 2;
        lo = (i == 0) ? 64'd0 : (((longint'(act_w[i]) >> G) << G) << 2);
        if (a >= lo && a < hi) return pat_of(i);
      end else if (m == 3) begin
        if (G >= 2) ad = ad | ((64'd1 << (G - 1)) - 1);
        if (ad == 64'hFFFF_FFFF) return pat_of(i);
        t = 0;
        while (((ad >> t) & 1) == 1) t++;
        size = 64'd1 << (t + 3);
        base = ((ad >> (t + 1)) << (t + 1)) << 2;
        if (a >= base && a < base + size) return pat_of(i);
      end
    end
    return 5'd0;
  endfunction

  task automatic reg_wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cfg_req.addr = off; cfg_req.write = 1'b1; cfg_req.wdata = d; cfg_req.wstrb = s; cfg_req.valid = 1'b1;
    @(posedge clk);
    model_write(off, d, s);
    #1;
    cfg_req.valid = 1'b0; cfg_req.write = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] off, output logic [31:0] d, output logic e);
    @(negedge clk);
    cfg_req.addr = off; cfg_req.write = 1'b0; cfg_req.wstrb = 4'h0; cfg_req.valid = 1'b1;
    #1;
    d = cfg_rsp.rdata;
    e = cfg_rsp.error;
    chk("rd_ready", 64'(cfg_rsp.ready), 64'd1);
    @(posedge clk);
    #1;
    cfg_req.valid = 1'b0;
  endtask

  task automatic chk_ar(input string tag, input logic [47:0] a, input logic [7:0] u, input logic [4:0] t);
    slv_req.ar.addr = a; slv_req.ar.user = u; slv_req.ar_valid = 1'b1;
    #1;
    chk(tag, 64'(mst_req.ar.user), 64'((u & 8'h07) | {t, 3'b000}));
  endtask

  task automatic chk_aw(input string tag, input logic [47:0] a, input logic [7:0] u, input logic [4:0] t);
    slv_req.aw.addr = a; slv_req.aw.user = u; slv_req.aw_valid = 1'b1;
    #1;
    chk(tag, 64'(mst_req.aw.user), 64'((u & 8'h07) | {t, 3'b000}));
  endtask

  function automatic logic [31:0] rand_addr(input logic [31:0] prev);
    int k;
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 2))
      0: return v;
      1: begin
        k = $urandom_range(1, 30);
        return (v & ~((32'd1 << k) - 32'd1)) | ((32'd1 << (k - 1)) - 32'd1);
      end
      default: return prev + 32'($urandom_range(0, 32'h0100_0000));
    endcase
  endfunction

  logic [31:0] rd;
  logic        er;
  logic [31:0] prev;
  logic [63:0] rdat;
  longint unsigned pa, noise;
  int j, s, w;
  logic [7:0] u;

  initial begin
    rst = 1'b1;
    slv_req = '0; mst_rsp = '0; cfg_req = '0;
    for (int i = 0; i < NW; i++) begin sh_w[i] = '0; act_w[i] = '0; end

    #12;
    chk_ar("rst_ar_tag", 48'h1000, 8'hFF, 5'd0);
    reg_rd(32'h50, rd, er);
    chk("rst_conf_rd", 64'(rd), 64'd0);
    chk("rst_conf_err", 64'(er), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    chk_ar("plan_noconf", 48'h1000, 8'hFF, 5'd0);

    // NAPOT table
    reg_wr(32'h04, 32'h09FF_FFFF, 4'hF);
    reg_wr(32'h08, 32'h10FF_FFFF, 4'hF);
    reg_wr(32'h0C, 32'h19FF_FFFF, 4'hF);
    reg_wr(32'h10, 32'h21FF_FFFF, 4'hF);
    reg_wr(32'h44, 32'h0001_8820, 4'hF);
    reg_wr(32'h50, 32'h0000_00FF, 4'hF);
    reg_wr(32'h00, 32'h1, 4'hF);
    chk_aw("napot_2000_0040", 48'h2000_0040, 8'h00, 5'd0);
    chk_aw("napot_4000_0000", 48'h4000_0000, 8'h05, 5'd1);
    chk_aw("napot_6800_0000", 48'h6800_0000, 8'hFF, 5'd2);
    chk_aw("napot_8100_0000", 48'h8100_0000, 8'h02, 5'd3);
    chk_aw("napot_nomatch",   48'h1000_0000, 8'hFF, 5'd0);
    chk_aw("napot_top_edge",  48'h4800_0000, 8'h00, 5'd0);

    // TOR table
    reg_wr(32'h04, 32'h0800_0000, 4'hF);
    reg_wr(32'h08, 32'h1000_0000, 4'hF);
    reg_wr(32'h0C, 32'h1800_0000, 4'hF);
    reg_wr(32'h10, 32'h2000_0000, 4'hF);
    reg_wr(32'h44, 32'h0002_14C7, 4'hF);
    reg_wr(32'h50, 32'h0000_0055, 4'hF);
    reg_wr(32'h00, 32'h1, 4'hF);
    chk_ar("tor_0",         48'h0,           8'h00, 5'd7);
    chk_ar("tor_3fff_fff8", 48'h3FFF_FFF8,   8'h00, 5'd6);
    chk_ar("tor_4000_0000", 48'h4000_0000,   8'h00, 5'd5);
    chk_ar("tor_7fff_fff8", 48'h7FFF_FFF8,   8'h00, 5'd4);
    chk_ar("tor_8000_0000", 48'h8000_0000,   8'h00, 5'd0);

    // shadow-only write must not change matching until commit
    reg_wr(32'h50, 32'h0, 4'hF);
    reg_wr(32'h00, 32'h1, 4'hF);
    chk_ar("all_off", 48'h0, 8'h00, 5'd0);
    reg_wr(32'h50, 32'h55, 4'hF);
    chk_ar("shadow_only", 48'h0, 8'h00, 5'd0);
    reg_rd(32'h50, rd, er);
    chk("shadow_conf_rd", 64'(rd), 64'h55);
    chk("shadow_conf_err", 64'(er), 64'd0);
    @(negedge clk);
    cfg_req.addr = 32'h0; cfg_req.write = 1'b1; cfg_req.wdata = 32'h1; cfg_req.wstrb = 4'hF; cfg_req.valid = 1'b1;
    #1;
    chk_ar("commit_cycle_old", 48'h0, 8'h00, 5'd0);
    @(posedge clk);
    model_write(32'h0, 32'h1, 4'hF);
    #1;
    cfg_req.valid = 1'b0; cfg_req.write = 1'b0;
    chk_ar("after_commit_e0", 48'h0,         8'h00, 5'd7);
    chk_ar("after_commit_e2", 48'h4000_0000, 8'h00, 5'd5);
    reg_rd(32'h00, rd, er);
    chk("commit_rd_zero", 64'(rd), 64'd0);

    // overlap priority
    reg_wr(32'h04, 32'h09FF_FFFF, 4'hF);
    reg_wr(32'h08, 32'h0BFF_FFFF, 4'hF);
    reg_wr(32'h44, 32'h0000_0123, 4'hF);
    reg_wr(32'h50, 32'h0000_000F, 4'hF);
    reg_wr(32'h00, 32'h1, 4'hF);
    chk_aw("overlap_low_wins", 48'h2000_0000, 8'h00, 5'd3);
    chk_aw("overlap_only_e1",  48'h3000_0000, 8'h00, 5'd9);

    // NA4 behaves as OFF; all-ones NAPOT covers the whole space
    reg_wr(32'h50, 32'h0000_0002, 4'hF);
    reg_wr(32'h00, 32'h1, 4'hF);
    chk_aw("na4_is_off", 48'h2000_0000, 8'h00, 5'd0);
    reg_wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    reg_wr(32'h44, 32'h0000_0015, 4'hF);
    reg_wr(32'h50, 32'h0000_0003, 4'hF);
    reg_wr(32'h00, 32'h1, 4'hF);
    chk_aw("napot_all_hi", 48'hFFFF_0000_0000, 8'h00, 5'h15);
    chk_ar("napot_all_lo", 48'h0, 8'hFF, 5'h15);

    // regbus map
    reg_rd(32'h80, rd, er);
    chk("unmapped_err", 64'(er), 64'd1);
    chk("unmapped_rd", 64'(rd), 64'd0);
    reg_wr(32'h04, 32'h0, 4'hF);
    reg_wr(32'h04, 32'hFFFF_FFAB, 4'h1);
    reg_rd(32'h04, rd, er);
    chk("wstrb_byte0", 64'(rd), 64'h0000_00AB);
    chk("wstrb_err", 64'(er), 64'd0);
    reg_wr(32'h04, 32'h1234_5678, 4'h6);
    reg_rd(32'h04, rd, er);
    chk("wstrb_mid", 64'(rd), 64'h0034_56AB);
    reg_wr(32'h4C, 32'hFFFF_FFFF, 4'hF);
    reg_rd(32'h4C, rd, er);
    chk("patid_last_mask", 64'(rd), 64'h000F_FFFF);
    reg_wr(32'h80, 32'hFFFF_FFFF, 4'hF);
    reg_rd(32'h50, rd, er);
    chk("unmapped_wr_ignored", 64'(rd), 64'h3);

    // pass-through of untouched fields
    mst_rsp.r.data = {$urandom, $urandom};
    mst_rsp.b.resp = 2'($urandom);
    rdat = {$urandom, $urandom};
    slv_req.w.data = rdat;
    #1;
    chk("pt_r_data", slv_rsp.r.data, mst_rsp.r.data);
    chk("pt_b_resp", 64'(slv_rsp.b.resp), 64'(mst_rsp.b.resp));
    chk("pt_w_data", mst_req.w.data, rdat);

    // randomized configurations against the model
    for (int r = 0; r < 40; r++) begin
      prev = 32'($urandom_range(0, 32'h0100_0000));
      for (int i = 0; i < MAXP; i++) begin
        prev = rand_addr(prev);
        reg_wr(32'(4 + 4 * i), prev, 4'hF);
      end
      for (int k = 0; k < NPW; k++) reg_wr(32'(4 * (PB + k)), $urandom, 4'hF);
      reg_wr(32'(4 * CW), $urandom, 4'hF);
      reg_wr(32'h0, 32'h1, 4'hF);
      for (int p = 0; p < 10; p++) begin
        j     = $urandom_range(0, MAXP - 1);
        s     = $urandom_range(0, 40);
        noise = {$urandom, $urandom} & ((64'd1 << s) - 64'd1);
        case ($urandom_range(0, 3))
          0:       pa = {$urandom, $urandom};
          1:       pa = (longint'(act_w[1 + j]) << 2) - 64'd4;
          default: pa = (longint'(act_w[1 + j]) << 2) ^ noise;
        endcase
        pa = pa & 64'h0000_FFFF_FFFF_FFFF;
        u  = 8'($urandom);
        chk_aw("rand_aw", 48'(pa), u, model_tag(pa));
        chk("rand_aw_addr", 64'(mst_req.aw.addr), pa);
        chk_ar("rand_ar", 48'(pa ^ 64'h8), ~u, model_tag(pa ^ 64'h8));
      end
      w = $urandom_range(1, NW - 1);
      reg_wr(32'(4 * w), $urandom, 4'($urandom));
      w = $urandom_range(0, NW + 3);
      reg_rd(32'(4 * w), rd, er);
      chk("rand_rd", 64'(rd), (w < NW) ? 64'(sh_w[w] & wmask_of(w)) : 64'd0);
      chk("rand_rd_err", 64'(er), (w < NW) ? 64'd0 : 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
